prog_mem: RTL

//  Parametrised synchronous program memory for the 8-bit teaching CPU (LD/LDI/ADD/ADDI/ST/JUMP ISA).

---
 rtl/prog_mem_pkg.sv | 22 ++
 rtl/prog_mem_ram.sv | 40 ++++
 rtl/prog_mem.sv | 120 ++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the program memory and its loaders.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_LD   = 8'h02;
    localparam logic [7:0] OP_ADDI = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h04;
    localparam logic [7:0] OP_ST   = 8'h05;
    localparam logic [7:0] OP_JUMP = 8'h06;

    // Index width for a DEPTH-entry array; never below one bit.
    function automatic int unsigned idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/prog_mem_ram.sv
// Single-port synchronous RAM with a registered read port; unmapped reads return zero.
module prog_mem_ram
    import prog_mem_pkg::*;
#(
    parameter int unsigned WW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [WW-1:0] wdata,
    input  logic          re,
    output logic [WW-1:0] rdata
);

    localparam int unsigned IW = idx_w(DEPTH);

    logic [WW-1:0] mem [DEPTH];
    logic          mapped;

    assign mapped = (32'(addr) < DEPTH);

    // Array is intentionally not reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we && mapped) begin
            mem[addr[IW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mapped ? mem[addr[IW-1:0]] : '0;
        end
    end

endmodule

// File: rtl/prog_mem.sv
// Program memory with registered read and streaming loader port.
// Optional even-parity protection per word when PROG_MEM_PARITY_EN is defined.
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] adrs,
    input  logic          rd,
    output logic [DW-1:0] dout,
    output logic          dvalid,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_len,
    input  logic [DW-1:0] ld_data,
    input  logic          ld_valid,
    output logic          ld_ready,
    output logic          ld_done,
    output logic          busy,
    output logic          par_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned P = 1;
`else
    localparam int unsigned P = 0;
`endif
    localparam int unsigned WW = DW + P;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    state_t        state, next_state;
    logic [AW-1:0] ptr;
    logic [LW-1:0] cnt, len, len_sel;
    logic          xfer, last, rd_ok;
    logic [AW-1:0] ram_addr;
    logic [WW-1:0] wword, rword;

    assign xfer     = ld_valid & ld_ready;
    assign last     = (cnt == len - LW'(1));
    assign rd_ok    = rd & (state == RUN);
    assign ram_addr = (state == LOAD) ? ptr : adrs;
    assign dout     = rword[DW-1:0];

    // Zero or oversized lengths load the whole array.
    always_comb begin
        len_sel = LW'(ld_len);
        if (ld_len == '0 || 32'(ld_len) > DEPTH) begin
            len_sel = LW'(DEPTH);
        end
    end

`ifdef PROG_MEM_PARITY_EN
    assign wword   = {^ld_data, ld_data};
    assign par_err = dvalid & (^rword);
`else
    assign wword   = ld_data;
    assign par_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (ld_start) next_state = LOAD;
            LOAD:    if (xfer && last) next_state = DONE;
            DONE:    next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Status flags are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            busy     <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b0;
            dvalid   <= 1'b0;
        end else begin
            state    <= next_state;
            busy     <= (next_state != RUN);
            ld_ready <= (next_state == LOAD);
            ld_done  <= (next_state == DONE);
            dvalid   <= rd_ok;
        end
    end

    // Pointer stops on the last word so it never leaves the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            cnt <= '0;
            len <= '0;
        end else if (state == RUN && ld_start) begin
            ptr <= '0;
            cnt <= '0;
            len <= len_sel;
        end else if (xfer && !last) begin
            ptr <= ptr + AW'(1);
            cnt <= cnt + LW'(1);
        end
    end

    prog_mem_ram #(
        .WW    (WW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (ram_addr),
        .we    (xfer),
        .wdata (wword),
        .re    (rd_ok),
        .rdata (rword)
    );

endmodule
